// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, ROM addressing and IF/ID pipeline register,
// with stall, redirect and halt/resume control plus a saturating fetch counter.
module inst_fetch #(
    parameter int unsigned      ADDR_WIDTH = 12,
    parameter logic [31:0]      RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    input  logic                  stall,
    input  logic                  redirect_en,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt_req,
    input  logic                  go,
    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc4,
    output logic [31:0]           if_instr,
    output logic                  halted,
    output logic [31:0]           fetch_count
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    localparam logic [ADDR_WIDTH-1:0] PcInit = RESET_PC[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] PcStep = ADDR_WIDTH'(4);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [ADDR_WIDTH-1:0] id_pc4_q, id_pc4_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           count_q, count_d;

    logic [ADDR_WIDTH-1:0] pc_next_seq;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  fetch;

    // Natural modulo-2^ADDR_WIDTH wrap; low two bits are forced clear on redirect.
    assign pc_next_seq     = pc_q + PcStep;
    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        instr_d  = instr_q;
        count_d  = count_q;
        fetch    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (redirect_en) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    if (halt_req) begin
                        state_d = StHalt;
                    end
                end else if (halt_req) begin
                    state_d = StHalt;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    fetch = 1'b1;
                end
            end
            StHalt: begin
                // Resuming costs one idle RUN entry; the first fetch happens there.
                valid_d = 1'b0;
                if (redirect_en) begin
                    pc_d = redirect_target;
                end
                if (go) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (fetch) begin
            valid_d  = 1'b1;
            id_pc_d  = pc_q;
            id_pc4_d = pc_next_seq;
            instr_d  = rom_data;
            pc_d     = pc_next_seq;
            if (count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= StRun;
            pc_q     <= PcInit;
            valid_q  <= 1'b0;
            id_pc_q  <= '0;
            id_pc4_q <= '0;
            instr_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            instr_q  <= instr_d;
            count_q  <= count_d;
        end
    end

    assign rom_addr    = pc_q;
    assign if_valid    = valid_q;
    assign if_pc       = 32'(id_pc_q);
    assign if_pc4      = 32'(id_pc4_q);
    assign if_instr    = instr_q;
    assign halted      = (state_q == StHalt);
    assign fetch_count = count_q;

endmodule
